ascon_fc_sequencer: RTL

// - Command-level controller for the fault-countermeasure Ascon wrapper (triplicated enc/dec + majority vote).
// - Accepts one command at a time from a host over a valid/ready handshake.
// - Sequences the cores: core reset, encryption, then optional decryption/verify.
// - Returns one status response per command, also over valid/ready; sits between the host bus and the FC wrapper.

---
 rtl/ascon_seq_pkg.sv | 32 +++
 rtl/ascon_fc_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ascon_seq_pkg.sv
// ---------------------------------------------------------------------------
// ascon_seq_pkg
// Shared definitions for the Ascon fault-countermeasure command sequencer:
//   state_t     - sequencer FSM states
//   cmd_mode_t  - host command encodings (cmd_mode port)
//   status_t    - response status encodings (rsp_status port)
// ---------------------------------------------------------------------------
package ascon_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ENC_RUN = 3'd2,
        S_DEC_RUN = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_ENC     = 2'b00,
        MODE_ENC_DEC = 2'b01,
        MODE_DEC     = 2'b10,
        MODE_RSVD    = 2'b11
    } cmd_mode_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_AUTH_FAIL = 2'b01,
        ST_TIMEOUT   = 2'b10,
        ST_BAD_CMD   = 2'b11
    } status_t;

endpackage

// File: rtl/ascon_fc_sequencer.sv
// ---------------------------------------------------------------------------
// ascon_fc_sequencer
// Command-level controller for the triplicated (fault-countermeasure) Ascon
// wrapper. Takes one host command at a time, clears the cores, runs
// encryption and/or decryption, and returns one status response.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   cmd_valid/ready/mode   host command handshake (ready only in IDLE)
//   fc_rst         core reset to the FC wrapper (held during CLEAR)
//   fc_enc_start   encryption_start, registered
//   fc_dec_start   decryption_start, registered
//   fc_enc_ready, fc_dec_ready, fc_auth   sticky status from the FC wrapper
//   rsp_valid/ready/status response handshake
//   busy           high whenever the FSM is not in IDLE
//   op_count       number of responses accepted by the host (wraps)
//
// Optional feature: define ASCON_SEQ_WATCHDOG_EN to bound each wait for
// fc_enc_ready / fc_dec_ready to WDOG_LIMIT cycles (status TIMEOUT).
// ---------------------------------------------------------------------------
module ascon_fc_sequencer
    import ascon_seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int CLR_CYCLES = 2,
    parameter int WDOG_LIMIT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    output logic             fc_rst,
    output logic             fc_enc_start,
    output logic             fc_dec_start,
    input  logic             fc_enc_ready,
    input  logic             fc_dec_ready,
    input  logic             fc_auth,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    if (CLR_CYCLES < 1 || WDOG_LIMIT < 1 || CNT_W < 2 || CNT_W > 30 ||
        CLR_CYCLES > (1 << CNT_W) || WDOG_LIMIT > (1 << CNT_W)) begin : g_bad_params
        $error("ascon_fc_sequencer: illegal parameter combination");
    end

    state_t           r_state, w_next;
    cmd_mode_t        r_mode, w_mode_d;
    status_t          r_status, w_status_d;
    logic [CNT_W-1:0] r_clr_cnt, w_clr_cnt_d;
    logic [CNT_W-1:0] r_op_cnt;
    logic             r_fc_rst, r_enc_start, r_dec_start;
    logic             w_wdog_fire;

`ifdef ASCON_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] r_wdog;
    logic             w_in_run;

    assign w_in_run    = (r_state == S_ENC_RUN) || (r_state == S_DEC_RUN);
    // Fires on the WDOG_LIMIT-th cycle spent waiting; a ready seen on that
    // same cycle still wins.
    assign w_wdog_fire = (r_wdog == CNT_W'(WDOG_LIMIT - 1)) &&
                         (((r_state == S_ENC_RUN) && !fc_enc_ready) ||
                          ((r_state == S_DEC_RUN) && !fc_dec_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (w_in_run && (w_next == r_state)) begin
            r_wdog <= r_wdog + CNT_W'(1);
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    // Next-state and next-register values
    always_comb begin
        w_next      = r_state;
        w_mode_d    = r_mode;
        w_status_d  = r_status;
        w_clr_cnt_d = r_clr_cnt;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_mode_d    = cmd_mode_t'(cmd_mode);
                    w_clr_cnt_d = CNT_W'(CLR_CYCLES - 1);
                    if (cmd_mode_t'(cmd_mode) == MODE_RSVD) begin
                        w_next     = S_RESP;
                        w_status_d = ST_BAD_CMD;
                    end else begin
                        w_next = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == '0) begin
                    w_next = (r_mode == MODE_DEC) ? S_DEC_RUN : S_ENC_RUN;
                end else begin
                    w_clr_cnt_d = r_clr_cnt - CNT_W'(1);
                end
            end
            S_ENC_RUN: begin
                if (fc_enc_ready) begin
                    if (r_mode == MODE_ENC_DEC) begin
                        w_next = S_DEC_RUN;
                    end else begin
                        w_next     = S_RESP;
                        w_status_d = ST_OK;
                    end
                end else if (w_wdog_fire) begin
                    w_next     = S_RESP;
                    w_status_d = ST_TIMEOUT;
                end
            end
            S_DEC_RUN: begin
                if (fc_dec_ready) begin
                    w_next     = S_RESP;
                    w_status_d = fc_auth ? ST_OK : ST_AUTH_FAIL;
                end else if (w_wdog_fire) begin
                    w_next     = S_RESP;
                    w_status_d = ST_TIMEOUT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_status    <= ST_OK;
            r_fc_rst    <= 1'b1;
            r_enc_start <= 1'b0;
            r_dec_start <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            r_state     <= w_next;
            r_status    <= w_status_d;
            // High exactly while in CLEAR, plus a one-cycle pulse on timeout.
            r_fc_rst    <= (w_next == S_CLEAR) || w_wdog_fire;
            // Start rises one cycle after entering the run state and drops
            // on the edge the FSM leaves it.
            r_enc_start <= (r_state == S_ENC_RUN) && (w_next == S_ENC_RUN);
            r_dec_start <= (r_state == S_DEC_RUN) && (w_next == S_DEC_RUN);
            if ((r_state == S_RESP) && rsp_ready) begin
                r_op_cnt <= r_op_cnt + CNT_W'(1);
            end
        end
    end

    // Command data registers
    always_ff @(posedge clk) begin
        r_mode    <= w_mode_d;
        r_clr_cnt <= w_clr_cnt_d;
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_status   = r_status;
    assign fc_rst       = r_fc_rst;
    assign fc_enc_start = r_enc_start;
    assign fc_dec_start = r_dec_start;
    assign op_count     = r_op_cnt;

endmodule
